// File: rtl/enemy_collision_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enemy_collision_pkg : arena geometry, direction indices, sweep states   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package enemy_collision_pkg;

   localparam int ORG_X     = 143;
   localparam int ORG_Y     = 34;
   localparam int TILE_COLS = 40;
   localparam int TILE_ROWS = 30;
   localparam int SPRITE_W  = 16;

   localparam int DIR_LEFT  = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_UP    = 2;
   localparam int DIR_DOWN  = 3;

   typedef enum logic [1:0] {
      ST_LATCH  = 2'd0,
      ST_PROBE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } sweep_state_t;

   // Probes k and k+1 share a direction, so k[2:1] is the direction index.
   function automatic logic signed [10:0] probe_dx(input logic [2:0] k);
      case (k)
         3'd0, 3'd1: probe_dx = -11'sd1;
         3'd2, 3'd3: probe_dx = 11'sd16;
         3'd4, 3'd6: probe_dx = 11'sd0;
         default:    probe_dx = 11'sd15;
      endcase
   endfunction

   function automatic logic signed [10:0] probe_dy(input logic [2:0] k);
      case (k)
         3'd0, 3'd2: probe_dy = 11'sd0;
         3'd1, 3'd3: probe_dy = 11'sd15;
         3'd4, 3'd5: probe_dy = -11'sd1;
         default:    probe_dy = 11'sd16;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_collision_tile_addr_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_addr_calc : pixel probe -> in-arena flag and block-map address      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tile_addr_calc #(
   parameter int TILE_COLS = 40,
   parameter int TILE_ROWS = 30,
   parameter int ORG_X     = 143,
   parameter int ORG_Y     = 34
) (
   input  logic signed [10:0] px,
   input  logic signed [10:0] py,
   output logic               in_arena,
   output logic [10:0]        addr
);

   logic signed [12:0] w_dx;
   logic signed [12:0] w_dy;
   logic [11:0]        w_col;
   logic [11:0]        w_row;
   logic [11:0]        w_row_base;

   // Widen before subtracting the origin so negative probes stay negative.
   assign w_dx = {{2{px[10]}}, px} - 13'(ORG_X);
   assign w_dy = {{2{py[10]}}, py} - 13'(ORG_Y);

   assign in_arena = !w_dx[12] && (w_dx[11:0] < 12'(16 * TILE_COLS)) &&
                     !w_dy[12] && (w_dy[11:0] < 12'(16 * TILE_ROWS));

   assign w_col = w_dx[11:0] >> 4;
   assign w_row = w_dy[11:0] >> 4;

   generate
      if (TILE_COLS == 40) begin : g_cols40
         assign w_row_base = (w_row << 5) + (w_row << 3);
      end else begin : g_cols_generic
         assign w_row_base = 12'(w_row * 12'(TILE_COLS));
      end
   endgenerate

   assign addr = 11'(w_row_base + w_col);

endmodule
`default_nettype wire

// File: rtl/enemy_collision.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enemy_collision : 11-cycle probe sweep producing enemy_blocked[3:0]      |
// | Option: ENEMY_COLLISION_BOMB_EN adds bomb_active / bomb_tile inputs      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module enemy_collision #(
   parameter int TILE_COLS = enemy_collision_pkg::TILE_COLS,
   parameter int TILE_ROWS = enemy_collision_pkg::TILE_ROWS,
   parameter int ORG_X     = enemy_collision_pkg::ORG_X,
   parameter int ORG_Y     = enemy_collision_pkg::ORG_Y
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  enemy_x,
   input  logic [9:0]  enemy_y,
   output logic        map_rd_en,
   output logic [10:0] map_addr,
   input  logic        map_solid,
`ifdef ENEMY_COLLISION_BOMB_EN
   input  logic        bomb_active,
   input  logic [10:0] bomb_tile,
`endif
   output logic [3:0]  enemy_blocked,
   output logic        sweep_done
);

   import enemy_collision_pkg::*;

   sweep_state_t      r_state;
   sweep_state_t      w_state_next;
   logic [9:0]        r_lx;
   logic [9:0]        r_ly;
   logic [2:0]        r_k;
   logic [3:0]        r_acc;
   logic              r_pend_valid;
   logic              r_pend_oob;
   logic              r_pend_bomb;
   logic [1:0]        r_pend_dir;

   logic signed [10:0] w_px;
   logic signed [10:0] w_py;
   logic               w_in_arena;
   logic [10:0]        w_tile_addr;
   logic               w_bomb_hit;
   logic               w_probe_active;
   logic               w_probe_solid;

   assign w_px = $signed({1'b0, r_lx}) + probe_dx(r_k);
   assign w_py = $signed({1'b0, r_ly}) + probe_dy(r_k);

   tile_addr_calc #(
      .TILE_COLS (TILE_COLS),
      .TILE_ROWS (TILE_ROWS),
      .ORG_X     (ORG_X),
      .ORG_Y     (ORG_Y)
   ) u_tile_addr_calc (
      .px       (w_px),
      .py       (w_py),
      .in_arena (w_in_arena),
      .addr     (w_tile_addr)
   );

`ifdef ENEMY_COLLISION_BOMB_EN
   assign w_bomb_hit = bomb_active && (w_tile_addr == bomb_tile);
`else
   assign w_bomb_hit = 1'b0;
`endif

   always_comb begin
      w_state_next   = r_state;
      map_rd_en      = 1'b0;
      map_addr       = 11'd0;
      w_probe_active = 1'b0;
      case (r_state)
         ST_LATCH:  w_state_next = ST_PROBE;
         ST_PROBE: begin
            w_probe_active = 1'b1;
            map_rd_en      = w_in_arena;
            map_addr       = w_in_arena ? w_tile_addr : 11'd0;
            if (r_k == 3'd7) w_state_next = ST_DRAIN;
         end
         ST_DRAIN:  w_state_next = ST_COMMIT;
         ST_COMMIT: w_state_next = ST_LATCH;
         default:   w_state_next = ST_LATCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_LATCH;
      else       r_state <= w_state_next;
   end

   // Out-of-arena and bomb hits ride the same one-cycle pipe as map reads.
   assign w_probe_solid = r_pend_oob || map_solid || r_pend_bomb;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lx          <= 10'd0;
         r_ly          <= 10'd0;
         r_k           <= 3'd0;
         r_acc         <= 4'd0;
         r_pend_valid  <= 1'b0;
         r_pend_oob    <= 1'b0;
         r_pend_bomb   <= 1'b0;
         r_pend_dir    <= 2'd0;
         enemy_blocked <= 4'b1111;
         sweep_done    <= 1'b0;
      end else begin
         sweep_done   <= 1'b0;
         r_pend_valid <= w_probe_active;
         r_pend_oob   <= !w_in_arena;
         r_pend_bomb  <= w_in_arena && w_bomb_hit;
         r_pend_dir   <= r_k[2:1];
         if (r_pend_valid && w_probe_solid) r_acc[r_pend_dir] <= 1'b1;
         case (r_state)
            ST_LATCH: begin
               r_lx  <= enemy_x;
               r_ly  <= enemy_y;
               r_k   <= 3'd0;
               r_acc <= 4'd0;
            end
            ST_PROBE:  r_k <= r_k + 3'd1;
            ST_COMMIT: begin
               enemy_blocked <= r_acc;
               sweep_done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_enemy_collision.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_enemy_collision : directed + random checks against a probe-rule model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_enemy_collision;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  enemy_x;
   logic [9:0]  enemy_y;
   logic        map_rd_en;
   logic [10:0] map_addr;
   logic        map_solid = 1'b0;
   logic [3:0]  enemy_blocked;
   logic        sweep_done;

   bit tile_map [0:1199];
   bit bomb_on = 1'b0;
   int bomb_t  = 0;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int rd_sum = 0;

`ifdef ENEMY_COLLISION_BOMB_EN
   logic        bomb_active;
   logic [10:0] bomb_tile;
   assign bomb_active = bomb_on;
   assign bomb_tile   = 11'(bomb_t);
`endif

   enemy_collision dut (
      .clk           (clk),
      .reset         (reset),
      .enemy_x       (enemy_x),
      .enemy_y       (enemy_y),
      .map_rd_en     (map_rd_en),
      .map_addr      (map_addr),
      .map_solid     (map_solid),
`ifdef ENEMY_COLLISION_BOMB_EN
      .bomb_active   (bomb_active),
      .bomb_tile     (bomb_tile),
`endif
      .enemy_blocked (enemy_blocked),
      .sweep_done    (sweep_done)
   );

   always #5 clk = ~clk;

   // Block map: data one cycle after the strobe, junk when no read was made.
   always @(posedge clk) begin
      if (map_rd_en) map_solid <= (map_addr < 11'd1200) ? tile_map[map_addr] : 1'b0;
      else           map_solid <= 1'($urandom);
   end

   always @(negedge clk) begin
      if (map_rd_en) begin
         rd_cnt++;
         rd_sum += int'(map_addr);
      end
   end

   // Expected blocking from the probe rules, using plain integer geometry.
   function automatic void model(input int x, input int y,
                                 output logic [3:0] blk, output int nrd, output int sum);
      int dxs [8] = '{-1, -1, 16, 16, 0, 15, 0, 15};
      int dys [8] = '{0, 15, 0, 15, -1, -1, 16, 16};
      blk = 4'b0000;
      nrd = 0;
      sum = 0;
      for (int k = 0; k < 8; k++) begin
         int px = x + dxs[k];
         int py = y + dys[k];
         bit solid;
         if (px >= 143 && px <= 143 + 639 && py >= 34 && py <= 34 + 479) begin
            int a = ((py - 34) / 16) * 40 + (px - 143) / 16;
            nrd++;
            sum += a;
            solid = tile_map[a] || (bomb_on && a == bomb_t);
         end else begin
            solid = 1'b1;
         end
         if (solid) blk[k / 2] = 1'b1;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_sweep(output int cycles);
      cycles = 0;
      while (1) begin
         @(negedge clk);
         cycles++;
         if (sweep_done === 1'b1) return;
         if (cycles >= 30) begin
            checks++;
            errors++;
            $error("FAIL sweep_timeout observed=no_sweep_done expected=pulse_within_30");
            return;
         end
      end
   endtask

   task automatic clear_map();
      foreach (tile_map[i]) tile_map[i] = 1'b0;
   endtask

   task automatic check_pos(input int x, input int y, input string tag);
      logic [3:0] exp_blk;
      int n, s, cyc;
      enemy_x = 10'(x);
      enemy_y = 10'(y);
      wait_sweep(cyc);
      rd_cnt = 0;
      rd_sum = 0;
      wait_sweep(cyc);
      model(x, y, exp_blk, n, s);
      chk({tag, "_blocked"}, 32'(enemy_blocked), 32'(exp_blk));
      chk({tag, "_reads"}, rd_cnt, n);
      chk({tag, "_addrsum"}, rd_sum, s);
      chk({tag, "_period"}, cyc, 11);
   endtask

   // Reset just released at this negedge: first result must arrive 11 cycles later.
   task automatic check_after_release(input int x, input int y, input string tag);
      logic [3:0] exp_blk;
      int n, s;
      rd_cnt = 0;
      rd_sum = 0;
      chk({tag, "_rel_blocked"}, 32'(enemy_blocked), 32'hF);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         chk({tag, "_hold_done"}, 32'(sweep_done), 32'd0);
         chk({tag, "_hold_blocked"}, 32'(enemy_blocked), 32'hF);
      end
      @(negedge clk);
      model(x, y, exp_blk, n, s);
      chk({tag, "_first_done"}, 32'(sweep_done), 32'd1);
      chk({tag, "_first_blocked"}, 32'(enemy_blocked), 32'(exp_blk));
      chk({tag, "_first_reads"}, rd_cnt, n);
   endtask

   initial begin
      logic [3:0] exp_blk;
      int n, s, cyc;
      clear_map();
      reset   = 1'b1;
      enemy_x = 10'd300;
      enemy_y = 10'd200;
      repeat (3) @(negedge clk);
      chk("reset_blocked", 32'(enemy_blocked), 32'hF);
      chk("reset_done", 32'(sweep_done), 32'd0);
      chk("reset_rd_en", 32'(map_rd_en), 32'd0);
      chk("reset_addr", 32'(map_addr), 32'd0);
      reset = 1'b0;
      check_after_release(300, 200, "por");

      check_pos(300, 200, "empty");
      check_pos(143, 34, "top_left");
      check_pos(767, 498, "bottom_right");
      check_pos(0, 0, "origin");
      tile_map[85] = 1'b1;
      check_pos(207, 66, "tile85");
      clear_map();

      // Position change mid-PROBE is only seen at the next LATCH.
      tile_map[416] = 1'b1;
      check_pos(300, 200, "pre_move");
      repeat (3) @(negedge clk);
      enemy_x = 10'd400;
      wait_sweep(cyc);
      model(300, 200, exp_blk, n, s);
      chk("move_old_blocked", 32'(enemy_blocked), 32'(exp_blk));
      wait_sweep(cyc);
      model(400, 200, exp_blk, n, s);
      chk("move_new_blocked", 32'(enemy_blocked), 32'(exp_blk));
      clear_map();

      // One-cycle reset in the middle of PROBE.
      tile_map[416] = 1'b1;
      enemy_x = 10'd400;
      wait_sweep(cyc);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_blocked", 32'(enemy_blocked), 32'hF);
      chk("midreset_rd_en", 32'(map_rd_en), 32'd0);
      reset = 1'b0;
      check_after_release(400, 200, "midreset");
      clear_map();

      for (int it = 0; it < 14; it++) begin
         foreach (tile_map[i]) tile_map[i] = ($urandom_range(0, 4) == 0);
         if (it < 10) check_pos($urandom_range(120, 800), $urandom_range(10, 530), "rand");
         else         check_pos($urandom_range(0, 1023), $urandom_range(0, 1023), "rand_wide");
      end
      clear_map();

`ifdef ENEMY_COLLISION_BOMB_EN
      bomb_on = 1'b1;
      bomb_t  = 85;
      check_pos(207, 66, "bomb85");
      for (int it = 0; it < 4; it++) begin
         int bx = $urandom_range(150, 760);
         int by = $urandom_range(40, 490);
         bomb_t = ((by + 1 - 34) / 16) * 40 + (bx + 16 - 143) / 16;
         check_pos(bx, by, "bomb_rand");
      end
      bomb_on = 1'b0;
      check_pos(207, 66, "bomb_off");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
